// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Optional feature macro: HAZARD_PERF_CNT_EN (see pipe_hazard_ctrl).
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_IDX_W       = 5;
  localparam int unsigned STATE_W         = 2;
  localparam int unsigned MEM_TIMEOUT_DEF = 16;
  localparam int unsigned CNT_W_DEF       = 8;
  localparam int unsigned PERF_W          = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } ctrl_state_e;

  // Encoding 3 is unreachable but is treated exactly like FAULT.
  function automatic logic is_fault_state(input ctrl_state_e s);
    return (s != ST_RUN) && (s != ST_MEM_WAIT);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator between the ID instruction and a load in EX.
// Purely combinational so a forwarding unit can reuse it.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_uses_rs1_i,
  input  logic                 id_uses_rs2_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic                 ex_mem_read_i,
  output logic                 load_use_o
);

  logic rd_valid;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is never written, so a load into it cannot create a hazard.
  assign rd_valid   = ex_mem_read_i && (ex_rd_i != REG_IDX_W'(0));
  assign rs1_hit    = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit    = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
  assign load_use_o = rd_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, EX redirect and dmem wait/timeout.
// Define HAZARD_PERF_CNT_EN to add the perf_* stall/flush/load-use counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_redirect,
  input  logic                 mem_req,
  input  logic                 dmem_ready,
  output logic                 pc_stall,
  output logic                 ifid_stall,
  output logic                 ifid_flush,
  output logic                 idex_stall,
  output logic                 idex_flush,
  output logic                 exmem_stall,
  output logic                 memwb_bubble,
  output logic                 mem_fault,
  output logic [STATE_W-1:0]   ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]    perf_stall_cycles,
  output logic [PERF_W-1:0]    perf_flushes,
  output logic [PERF_W-1:0]    perf_load_use
`endif
);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_fault_q, mem_fault_d;
  logic             freeze;
  logic             load_use;

  pipe_hazard_ctrl_hazard_detect u_hazard_detect (
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .ex_rd_i       (ex_rd),
    .ex_mem_read_i (ex_mem_read),
    .load_use_o    (load_use)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  // Next state, wait counter and stall/flush priority.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mem_fault_d  = mem_fault_q;
    freeze       = 1'b0;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_req && !dmem_ready) begin
          freeze     = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
            state_d     = ST_FAULT;
            mem_fault_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        freeze = 1'b1;
      end
    endcase

    // EX holds while frozen, so a redirect or load-use is simply deferred.
    if (freeze) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      exmem_stall  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end
  end

  assign mem_fault  = mem_fault_q;
  assign ctrl_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
  logic [PERF_W-1:0] perf_flush_q, perf_flush_d;
  logic [PERF_W-1:0] perf_lu_q, perf_lu_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_lu_q    <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_lu_q    <= perf_lu_d;
    end
  end

  // Counters wrap naturally and stop once the fault is latched.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    perf_lu_d    = perf_lu_q;
    if (!is_fault_state(state_q)) begin
      if (pc_stall) begin
        perf_stall_d = perf_stall_q + PERF_W'(1);
      end
      if (!freeze && ex_redirect) begin
        perf_flush_d = perf_flush_q + PERF_W'(1);
      end
      if (!freeze && !ex_redirect && load_use) begin
        perf_lu_d = perf_lu_q + PERF_W'(1);
      end
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flush_q;
  assign perf_load_use     = perf_lu_q;
`endif

endmodule
